// File: rtl/sys_arr_row_db.sv
// sys_arr_row_db: one row of a weight-stationary systolic MAC array.
// Activations enter PE0 and shift right one PE per cycle. Weights and partial
// sums flow top to bottom. Each PE has a shadow weight register that loads in
// the background and an active weight register that swaps in when the swap
// marker travelling with the data reaches that PE. Because the marker moves in
// lockstep with the samples, no sample is computed with a mix of old and new
// weights.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        synchronous active-high reset, clears every register
//   active       datain valid for PE0
//   wswap        swap marker for PE0, travels right with the data
//   datain       activation into PE0
//   win          weights from the row above, slice i feeds PE i
//   wwrite       per-PE shadow-weight write strobe
//   sumin        partial sums from the row above, slice i feeds PE i
//   signed_mode  1 = two's-complement data, weights and sums
//   sat_mode     1 = saturate on overflow, 0 = wrap
//   maccout      registered partial sums to the row below
//   activeout    per-PE registered valid for maccout
//   wout         registered win passthrough to the row below
//   wwriteout    registered wwrite passthrough
//   dataout      data leaving PE COLS-1
//   swapout      swap marker leaving PE COLS-1
module sys_arr_row_db #(
    parameter int unsigned COLS   = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    active,
    input  logic                    wswap,
    input  logic [DATA_W-1:0]       datain,
    input  logic [COLS*DATA_W-1:0]  win,
    input  logic [COLS-1:0]         wwrite,
    input  logic [COLS*ACC_W-1:0]   sumin,
    input  logic                    signed_mode,
    input  logic                    sat_mode,
    output logic [COLS*ACC_W-1:0]   maccout,
    output logic [COLS-1:0]         activeout,
    output logic [COLS*DATA_W-1:0]  wout,
    output logic [COLS-1:0]         wwriteout,
    output logic [DATA_W-1:0]       dataout,
    output logic                    swapout
);

    // Product width and the extended adder width (one guard bit for overflow)
    localparam int unsigned PW = 2 * DATA_W;
    localparam int unsigned EW = ACC_W + 1;

    // Per-PE pipeline and weight state
    logic [DATA_W-1:0] r_data [COLS];
    logic [DATA_W-1:0] r_wsh  [COLS];
    logic [DATA_W-1:0] r_wact [COLS];
    logic [DATA_W-1:0] r_wout [COLS];
    logic [ACC_W-1:0]  r_macc [COLS];
    logic [COLS-1:0]   r_act;
    logic [COLS-1:0]   r_swp;
    logic [COLS-1:0]   r_wwo;

    // Per-PE inputs after the left-to-right chaining
    logic [COLS-1:0]   w_a_in;
    logic [COLS-1:0]   w_s_in;
    logic [DATA_W-1:0] w_d_in  [COLS];
    logic [DATA_W-1:0] w_win   [COLS];
    logic [DATA_W-1:0] w_weff  [COLS];
    logic [ACC_W-1:0]  w_sumin [COLS];
    logic [ACC_W-1:0]  w_mac   [COLS];

    // Multiply-accumulate with sign/zero extension and optional saturation.
    // The product is formed at 2*DATA_W bits (the low bits of the extended
    // product are exact for both signednesses), then widened by one guard bit
    // beyond ACC_W so both signed and unsigned overflow are visible.
    function automatic logic [ACC_W-1:0] mac_f(
        input logic [DATA_W-1:0] d,
        input logic [DATA_W-1:0] w,
        input logic [ACC_W-1:0]  s,
        input logic              sgn,
        input logic              sat
    );
        logic [PW-1:0]    d_x;
        logic [PW-1:0]    w_x;
        logic [PW-1:0]    prod;
        logic [EW-1:0]    prod_x;
        logic [EW-1:0]    s_x;
        logic [EW-1:0]    sum;
        logic [ACC_W-1:0] res;
        d_x    = sgn ? {{DATA_W{d[DATA_W-1]}}, d} : {{DATA_W{1'b0}}, d};
        w_x    = sgn ? {{DATA_W{w[DATA_W-1]}}, w} : {{DATA_W{1'b0}}, w};
        prod   = d_x * w_x;
        prod_x = sgn ? {{(EW-PW){prod[PW-1]}}, prod} : {{(EW-PW){1'b0}}, prod};
        s_x    = sgn ? {s[ACC_W-1], s} : {1'b0, s};
        sum    = prod_x + s_x;
        res    = sum[ACC_W-1:0];
        if (sat) begin
            if (sgn) begin
                // Guard bit disagreeing with the ACC_W sign bit means overflow;
                // the guard bit carries the true sign.
                if (sum[EW-1] != sum[EW-2]) begin
                    res = sum[EW-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
                end
            end else if (sum[EW-1]) begin
                res = {ACC_W{1'b1}};
            end
        end
        return res;
    endfunction

    // Chain the PEs and compute each PE's next partial sum
    for (genvar g = 0; g < COLS; g++) begin : g_pe
        if (g == 0) begin : g_head
            assign w_a_in[g] = active;
            assign w_s_in[g] = wswap;
            assign w_d_in[g] = datain;
        end else begin : g_link
            assign w_a_in[g] = r_act[g-1];
            assign w_s_in[g] = r_swp[g-1];
            assign w_d_in[g] = r_data[g-1];
        end

        assign w_win[g]   = win[g*DATA_W +: DATA_W];
        assign w_sumin[g] = sumin[g*ACC_W +: ACC_W];

        // A swap arriving this cycle already uses the shadow value for this
        // sample; the shadow is read before any coincident write lands.
        assign w_weff[g] = w_s_in[g] ? r_wsh[g] : r_wact[g];

        assign w_mac[g] = mac_f(w_d_in[g], w_weff[g], w_sumin[g],
                                signed_mode, sat_mode);

        assign maccout[g*ACC_W +: ACC_W]  = r_macc[g];
        assign wout[g*DATA_W +: DATA_W]   = r_wout[g];
    end

    // Pipeline, weight buffers and accumulators
    always_ff @(posedge clk) begin
        if (reset) begin
            r_act <= '0;
            r_swp <= '0;
            r_wwo <= '0;
            for (int i = 0; i < COLS; i++) begin
                r_data[i] <= '0;
                r_wsh[i]  <= '0;
                r_wact[i] <= '0;
                r_wout[i] <= '0;
                r_macc[i] <= '0;
            end
        end else begin
            r_act <= w_a_in;
            r_swp <= w_s_in;
            r_wwo <= wwrite;
            for (int i = 0; i < COLS; i++) begin
                r_data[i] <= w_d_in[i];
                r_wout[i] <= w_win[i];
                if (wwrite[i]) begin
                    r_wsh[i] <= w_win[i];
                end
                if (w_s_in[i]) begin
                    r_wact[i] <= r_wsh[i];
                end
                if (w_a_in[i]) begin
                    r_macc[i] <= w_mac[i];
                end
            end
        end
    end

    assign activeout = r_act;
    assign wwriteout = r_wwo;
    assign dataout   = r_data[COLS-1];
    assign swapout   = r_swp[COLS-1];

endmodule

// File: tb/tb_sys_arr_row_db.sv
// Directed bench for sys_arr_row_db (COLS=4, DATA_W=8, ACC_W=16).
module tb_sys_arr_row_db;

    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int AW   = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 active;
    logic                 wswap;
    logic [DW-1:0]        datain;
    logic [COLS*DW-1:0]   win;
    logic [COLS-1:0]      wwrite;
    logic [COLS*AW-1:0]   sumin;
    logic                 signed_mode;
    logic                 sat_mode;
    logic [COLS*AW-1:0]   maccout;
    logic [COLS-1:0]      activeout;
    logic [COLS*DW-1:0]   wout;
    logic [COLS-1:0]      wwriteout;
    logic [DW-1:0]        dataout;
    logic                 swapout;

    int total = 0;
    int bad   = 0;

    sys_arr_row_db #(.COLS(COLS), .DATA_W(DW), .ACC_W(AW)) dut (
        .clk(clk), .reset(reset), .active(active), .wswap(wswap),
        .datain(datain), .win(win), .wwrite(wwrite), .sumin(sumin),
        .signed_mode(signed_mode), .sat_mode(sat_mode),
        .maccout(maccout), .activeout(activeout), .wout(wout),
        .wwriteout(wwriteout), .dataout(dataout), .swapout(swapout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] mo(input int i);
        return maccout[i*AW +: AW];
    endfunction

    task automatic all_zero(input string tag);
        chk({tag, "_macc_lo"}, maccout[31:0], 32'h0);
        chk({tag, "_macc_hi"}, maccout[63:32], 32'h0);
        chk({tag, "_act"}, 32'(activeout), 32'h0);
        chk({tag, "_wout"}, wout, 32'h0);
        chk({tag, "_wwo"}, 32'(wwriteout), 32'h0);
        chk({tag, "_dout"}, 32'(dataout), 32'h0);
        chk({tag, "_swp"}, 32'(swapout), 32'h0);
    endtask

    task automatic drain(input int n);
        active = 1'b0;
        wswap  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // 1. Reset with random inputs, then a sample against zero weights
        reset       = 1'b1;
        active      = 1'($urandom);
        wswap       = 1'($urandom);
        datain      = 8'($urandom);
        win         = $urandom;
        wwrite      = 4'($urandom);
        sumin       = {$urandom, $urandom};
        signed_mode = 1'($urandom);
        sat_mode    = 1'($urandom);
        tick();
        tick();
        all_zero("reset");

        reset       = 1'b0;
        active      = 1'b1;
        wswap       = 1'b0;
        datain      = 8'd5;
        win         = '0;
        wwrite      = '0;
        sumin       = {4{16'd7}};
        signed_mode = 1'b0;
        sat_mode    = 1'b0;
        tick();
        chk("w0_pe0", 32'(mo(0)), 32'd7);
        chk("w0_act", 32'(activeout), 32'h1);
        active = 1'b0;
        tick();
        tick();
        tick();
        chk("w0_pe3", 32'(mo(3)), 32'd7);
        drain(1);

        // 2. Load shadows then swap on the first sample
        win    = {8'd4, 8'd3, 8'd2, 8'd1};
        wwrite = 4'hF;
        tick();
        chk("ld_wout", wout, 32'h04030201);
        chk("ld_wwo", 32'(wwriteout), 32'hF);
        wwrite = '0;
        win    = '0;
        active = 1'b1;
        wswap  = 1'b1;
        datain = 8'd5;
        sumin  = '0;
        tick();
        chk("sw_pe0", 32'(mo(0)), 32'd5);
        chk("sw_act0", 32'(activeout), 32'h1);
        chk("sw_wwo0", 32'(wwriteout), 32'h0);
        active = 1'b0;
        wswap  = 1'b0;
        datain = 8'd0;
        tick();
        chk("sw_pe1", 32'(mo(1)), 32'd10);
        chk("sw_act1", 32'(activeout), 32'h2);
        tick();
        chk("sw_pe2", 32'(mo(2)), 32'd15);
        chk("sw_act2", 32'(activeout), 32'h4);
        tick();
        chk("sw_pe3", 32'(mo(3)), 32'd20);
        chk("sw_act3", 32'(activeout), 32'h8);
        chk("sw_dout", 32'(dataout), 32'd5);
        chk("sw_swp", 32'(swapout), 32'd1);
        tick();
        chk("sw_dout_next", 32'(dataout), 32'd0);
        chk("sw_swp_next", 32'(swapout), 32'd0);

        // 3. Stream; shadow 7s written early, swap on sample 10
        for (int n = 0; n < 17; n++) begin
            active = (n < 14);
            datain = 8'd1;
            wswap  = (n == 10);
            win    = (n == 2) ? {4{8'd7}} : '0;
            wwrite = (n == 2) ? 4'hF : 4'h0;
            tick();
            if (n == 2) chk("db_wout", wout, 32'h07070707);
            for (int i = 0; i < COLS; i++) begin
                int k;
                k = n - i;
                if (k >= 0 && k < 14) begin
                    chk($sformatf("db_s%0d_pe%0d", k, i), 32'(mo(i)),
                        (k >= 10) ? 32'd7 : 32'(i + 1));
                end
            end
        end
        win    = '0;
        wwrite = '0;
        drain(2);

        // 4. Signed vs unsigned: 0x80 * 0xFF
        win    = {4{8'hFF}};
        wwrite = 4'hF;
        tick();
        wwrite      = '0;
        win         = '0;
        signed_mode = 1'b1;
        active      = 1'b1;
        wswap       = 1'b1;
        datain      = 8'h80;
        sumin       = '0;
        tick();
        chk("sg_pe0", 32'(mo(0)), 32'h0080);
        drain(3);
        chk("sg_pe3", 32'(mo(3)), 32'h0080);
        drain(1);
        signed_mode = 1'b0;
        active      = 1'b1;
        tick();
        chk("us_pe0", 32'(mo(0)), 32'h7F80);
        drain(3);
        chk("us_pe3", 32'(mo(3)), 32'h7F80);
        drain(1);

        // 5. Overflow: 16*16 on top of a near-full sum
        win    = {4{8'd16}};
        wwrite = 4'hF;
        tick();
        wwrite      = '0;
        win         = '0;
        signed_mode = 1'b1;
        sat_mode    = 1'b1;
        active      = 1'b1;
        wswap       = 1'b1;
        datain      = 8'd16;
        sumin       = {4{16'h7FF0}};
        tick();
        chk("ov_ssat_pe0", 32'(mo(0)), 32'h7FFF);
        drain(3);
        chk("ov_ssat_pe3", 32'(mo(3)), 32'h7FFF);
        drain(1);
        sat_mode = 1'b0;
        active   = 1'b1;
        tick();
        chk("ov_swrap", 32'(mo(0)), 32'h80F0);
        drain(4);
        signed_mode = 1'b0;
        sat_mode    = 1'b1;
        sumin       = {4{16'hFFF0}};
        active      = 1'b1;
        tick();
        chk("ov_usat", 32'(mo(0)), 32'hFFFF);
        drain(4);
        sat_mode = 1'b0;
        active   = 1'b1;
        tick();
        chk("ov_uwrap", 32'(mo(0)), 32'h00F0);
        drain(4);

        // 6a. Shadow write on PE2 coinciding with the swap reaching PE2
        sumin  = '0;
        win    = {4{8'd3}};
        wwrite = 4'hF;
        tick();
        wwrite = '0;
        win    = '0;
        active = 1'b1;
        wswap  = 1'b1;
        datain = 8'd2;
        tick();
        active = 1'b0;
        wswap  = 1'b0;
        datain = 8'd0;
        tick();
        win    = 32'h00090000;
        wwrite = 4'b0100;
        tick();
        chk("col_pe2_old", 32'(mo(2)), 32'd6);
        chk("col_pe0", 32'(mo(0)), 32'd6);
        wwrite = '0;
        win    = '0;
        tick();
        chk("col_pe3", 32'(mo(3)), 32'd6);
        tick();
        active = 1'b1;
        datain = 8'd2;
        tick();
        drain(2);
        chk("col_wact_old", 32'(mo(2)), 32'd6);
        drain(1);
        active = 1'b1;
        wswap  = 1'b1;
        datain = 8'd2;
        tick();
        drain(2);
        chk("col_wsh_new", 32'(mo(2)), 32'd18);
        drain(2);

        // 6b. Reset in the middle of an active wave
        active = 1'b1;
        datain = 8'd1;
        sumin  = {4{16'd5}};
        win    = {4{8'hAA}};
        wwrite = 4'hF;
        tick();
        tick();
        chk("mw_act", 32'(activeout), 32'h3);
        reset = 1'b1;
        tick();
        all_zero("mw_rst");
        reset  = 1'b0;
        active = 1'b0;
        win    = '0;
        wwrite = '0;
        datain = 8'd0;
        tick();
        tick();
        tick();
        chk("mw_noresume_act", 32'(activeout), 32'h0);
        chk("mw_noresume_lo", maccout[31:0], 32'h0);
        chk("mw_noresume_hi", maccout[63:32], 32'h0);
        active = 1'b1;
        datain = 8'd3;
        tick();
        chk("mw_wcleared", 32'(mo(0)), 32'd5);
        drain(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sys_arr_row_db.md
# sys_arr_row_db

Parametrised weight-stationary systolic array row with double-buffered weights, signed/unsigned arithmetic and optional saturating accumulation. One instance forms one horizontal row of the MMU array. Activations enter at the left and shift right one PE per cycle. Partial sums and weights move top to bottom between rows. New weights load into per-PE shadow registers while the row computes, then swap in on a wavefront that travels with the data.

## Interface
Parameters:
- COLS, 4: number of PEs in the row (≥2).
- DATA_W, 8: activation/weight width.
- ACC_W, 16: partial-sum width; must be ≥ 2*DATA_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- active  in  1  datain valid for PE0.
- wswap  in  1  swap marker for PE0; travels right with data.
- datain  in  DATA_W  activation into PE0.
- win  in  COLS*DATA_W  weights from the row above; slice i feeds PE i.
- wwrite  in  COLS  per-PE shadow-weight write strobe.
- sumin  in  COLS*ACC_W  partial sums from the row above.
- signed_mode  in  1  1 = two's-complement data, weights and sums.
- sat_mode  in  1  1 = saturate on overflow; 0 = wrap.
- maccout  out  COLS*ACC_W  registered partial sums to the row below.
- activeout  out  COLS  per-PE registered valid for maccout.
- wout  out  COLS*DATA_W  registered win passthrough to the row below.
- wwriteout  out  COLS  registered wwrite passthrough.
- dataout  out  DATA_W  data leaving PE COLS-1.
- swapout  out  1  swap marker leaving PE COLS-1.

## Operation
- PE i inputs:
  - PE0 takes (active, datain, wswap).
  - PE i>0 takes PE i-1's registered (activeout[i-1], data reg, swap reg).
- Per PE i, every cycle:
  - data_i ← d_in
  - act_i ← a_in
  - swp_i ← s_in
  - wout_i ← win_i
  - wwriteout[i] ← wwrite[i]
- Shadow load: wwrite[i]=1 → wsh_i ← win_i.
- Swap: s_in=1 → wact_i ← wsh_i. The pre-write shadow value is used when wwrite[i] and s_in coincide; the shadow still takes the new win_i.
- MAC:
  - a_in=1 → macc_i ← sumin_i + d_in × w_eff, where w_eff = wsh_i if s_in=1 that cycle, else wact_i.
  - a_in=0 → macc_i holds.
- Arithmetic:
  - Operands are sign-extended when signed_mode=1, zero-extended otherwise.
  - The product is 2*DATA_W bits, extended to ACC_W+1 bits, then added to extended sumin.
  - sat_mode=1 clamps overflow: signed to [−2^(ACC_W−1), 2^(ACC_W−1)−1]; unsigned to 2^ACC_W−1.
  - sat_mode=0 keeps the low ACC_W bits.
- Mode inputs are sampled every cycle. They must stay stable while any act_i or a_in is 1; changing them mid-wave gives undefined sums.
- Reset (including mid-wave) clears every register on the next edge: macc, act, data, swp, wact, wsh, wout, wwriteout → 0. Inputs present during reset are ignored.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Sample injected at PE0 on cycle t:
  - Reaches PE i's input at t+i.
  - maccout_i and activeout[i] valid at t+i+1.
  - dataout/swapout at t+COLS.
- wout/wwriteout: 1-cycle latency, independent of active.
- Throughput is one sample per cycle; there is no back-pressure.
- Swap wavefront: a wswap asserted with sample k makes every PE use the new weights for sample k onward, so no PE mixes weights within one sample.
- Shadow write visibility: a write landing at cycle c is usable by a swap arriving at cycle ≥ c+1.

## Test plan
Bench configuration: COLS=4, DATA_W=8, ACC_W=16.

1. **Reset:** assert reset 2 cycles with random inputs → all outputs 0x0; first sample after release computes with weight 0 (maccout = sumin).
2. **Load and swap:** win={4,3,2,1} with wwrite=4'hF for one cycle, then active=1, wswap=1, datain=5, sumin=0 → maccout_0..3 = 5,10,15,20 at t+1..t+4; activeout one-hot walks 0001→1000; dataout=5 and swapout=1 at t+4.
3. **Double buffer:** stream datain=1 continuously with weights {4,3,2,1} active; write shadow 7s without a swap → outputs stay 1,2,3,4. Pulse wswap on sample 10 → samples ≥10 give 7 in every PE, samples <10 unchanged, at every column.
4. **Signed/unsigned:** datain=0x80, weight=0xFF, sumin=0 → signed_mode=1 gives 0x0080; signed_mode=0 gives 0x7F80.
5. **Overflow:** datain=16, weight=16, sumin=0x7FF0, signed_mode=1 → sat_mode=1 gives 0x7FFF; sat_mode=0 gives 0x80F0. Unsigned, sumin=0xFFF0, sat_mode=1 → 0xFFFF.
6. **Collision and mid-wave reset:** wwrite[2] coincides with the swap at PE2 → PE2 uses the old shadow and the shadow holds the new win. Separately, reset during an active wave → all outputs 0 next cycle and the wave does not resume.
